pipelined_cla_addsub: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor for the integer datapath.
- Replaces the fixed 32-bit combinational CLA where timing needs it.
- Operand width, CLA group size and pipeline depth are generic; add/sub mode and carry/borrow-in are selected per transaction.
- Produces sum plus carry, signed-overflow and zero flags; valid/ready on both sides, full throughput (1 op/cycle) when not back-pressured.

---
 rtl/pipelined_cla_addsub.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. The operand is split into STAGES
// segments, one segment is added per stage, and valid bits travel with the data.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_c,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG    = WIDTH / STAGES;
    localparam int GROUPS = SEG / BLOCK;

    if (STAGES < 1 || STAGES > WIDTH / BLOCK || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_param_check
        $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK and STAGES in 1..WIDTH/BLOCK");
    end

    // One segment: groups of BLOCK bits with full lookahead, group carries rippled.
    // Returns {carry out of segment, segment sum}.
    function automatic logic [SEG:0] cla_segment(
        input logic [SEG-1:0] a_i,
        input logic [SEG-1:0] b_i,
        input logic           cin_i
    );
        logic [SEG-1:0] gen;
        logic [SEG-1:0] prop;
        logic [SEG:0]   carry;
        logic           chain;
        logic           term;
        gen   = a_i & b_i;
        prop  = a_i ^ b_i;
        carry = {(SEG+1){1'b0}};
        carry[0] = cin_i;
        for (int grp = 0; grp < GROUPS; grp++) begin
            for (int i = 0; i < BLOCK; i++) begin
                chain = carry[grp*BLOCK];
                for (int j = 0; j <= i; j++) begin
                    chain = chain & prop[grp*BLOCK+j];
                end
                for (int j = 0; j <= i; j++) begin
                    term = gen[grp*BLOCK+j];
                    for (int m = j + 1; m <= i; m++) begin
                        term = term & prop[grp*BLOCK+m];
                    end
                    chain = chain | term;
                end
                carry[grp*BLOCK+i+1] = chain;
            end
        end
        return {carry[SEG], prop ^ carry[SEG-1:0]};
    endfunction

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still needed from this stage onwards.
        localparam int IN_W = WIDTH - k * SEG;

        logic [IN_W-1:0]        src_a_s;
        logic [IN_W-1:0]        src_b_s;
        logic                   src_c_s;
        logic                   src_v_s;
        logic [SEG:0]           seg_s;
        logic [(k+1)*SEG-1:0]   res_next_s;
        logic [(k+1)*SEG-1:0]   res_d;
        logic [(k+1)*SEG-1:0]   res_q;
        logic                   vld_d;
        logic                   vld_q;
        logic                   cy_d;
        logic                   cy_q;

        if (k == 0) begin : g_src
            // Stage 0 takes operands and carry directly from the input side
            always_comb begin
                src_a_s = input_a;
                src_b_s = b_eff_s;
                src_c_s = cin_eff_s;
                src_v_s = in_valid & adv_s;
            end
        end else begin : g_src
            // Later stages take skewed operands and carry from the previous register
            always_comb begin
                src_a_s = g_stage[k-1].g_fwd.opa_q;
                src_b_s = g_stage[k-1].g_fwd.opb_q;
                src_c_s = g_stage[k-1].cy_q;
                src_v_s = g_stage[k-1].vld_q;
            end
        end

        // Add this stage's segment and append it above the completed low segments
        always_comb begin
            seg_s = cla_segment(src_a_s[SEG-1:0], src_b_s[SEG-1:0], src_c_s);
        end

        if (k == 0) begin : g_res
            // First segment has nothing below it
            always_comb begin
                res_next_s = seg_s[SEG-1:0];
            end
        end else begin : g_res
            // Completed low segments ride along so all segments exit together
            always_comb begin
                res_next_s = {seg_s[SEG-1:0], g_stage[k-1].res_q};
            end
        end

        // Load from predecessor on advance, otherwise hold
        always_comb begin
            if (adv_s) begin
                vld_d = src_v_s;
                cy_d  = seg_s[SEG];
                res_d = res_next_s;
            end else begin
                vld_d = vld_q;
                cy_d  = cy_q;
                res_d = res_q;
            end
        end

        // Stage valid, carry and partial result registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= {((k+1)*SEG){1'b0}};
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                res_q <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int FW = IN_W - SEG;

            logic [FW-1:0] opa_d;
            logic [FW-1:0] opa_q;
            logic [FW-1:0] opb_d;
            logic [FW-1:0] opb_q;

            // Forward the not-yet-added operand bits one more stage
            always_comb begin
                if (adv_s) begin
                    opa_d = src_a_s[IN_W-1:SEG];
                    opb_d = src_b_s[IN_W-1:SEG];
                end else begin
                    opa_d = opa_q;
                    opb_d = opb_q;
                end
            end

            // Skewed operand registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= {FW{1'b0}};
                    opb_q <= {FW{1'b0}};
                end else begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit
            always_comb begin
                if (adv_s) begin
                    ovf_d = seg_s[SEG] ^ seg_s[SEG-1] ^ src_a_s[SEG-1] ^ src_b_s[SEG-1];
                end else begin
                    ovf_d = ovf_q;
                end
            end

            // Overflow flag register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    // Global advance and add/subtract operand conditioning
    always_comb begin
        adv_s     = out_ready | ~g_stage[STAGES-1].vld_q;
        b_eff_s   = sub ? ~input_b : input_b;
        cin_eff_s = carry_in ^ sub;
    end

    assign in_ready  = adv_s;
    assign out_valid = g_stage[STAGES-1].vld_q;
    assign output_c  = g_stage[STAGES-1].res_q;
    assign carry_out = g_stage[STAGES-1].cy_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
    assign zero      = (g_stage[STAGES-1].res_q == {WIDTH{1'b0}});

endmodule
